// File: rtl/u_fetch_redirect_pkg.sv
// Shared MIPS fetch-stage definitions: default widths, reset PC and the
// encoding of the fetch redirect state machine.
package u_fetch_redirect_pkg;

  // Default datapath width for PC, jump target and link data.
  localparam int DATA_WIDTH_DEF = 32;

  // Default PC loaded while reset is asserted.
  localparam int unsigned RESET_PC_DEF = 0;

  // Two-bit state encodings for the fetch redirect FSM.
  localparam logic [1:0] ST_RUN_ENC      = 2'd0;
  localparam logic [1:0] ST_PEND_ENC     = 2'd1;
  localparam logic [1:0] ST_REDIRECT_ENC = 2'd2;
  localparam logic [1:0] ST_HALTED_ENC   = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN      = ST_RUN_ENC,
    ST_PEND     = ST_PEND_ENC,
    ST_REDIRECT = ST_REDIRECT_ENC,
    ST_HALTED   = ST_HALTED_ENC
  } fetch_state_t;

endpackage : u_fetch_redirect_pkg

// File: rtl/u_fetch_redirect.sv
// Fetch PC generator with jump redirect. A jump accepted while the hazard
// unit stalls is parked in PEND until the stall clears. The cycle after a
// target is loaded is REDIRECT, which flushes the IF/ID slot and optionally
// strobes the link value. HALT parks the machine until reset.
module u_fetch_redirect
  import u_fetch_redirect_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_stall,
  input  logic                  i_halt,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_pcjump,
  input  logic                  i_return,
  input  logic [DATA_WIDTH-1:0] i_return_address,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_flush,
  output logic                  o_link_valid,
  output logic [DATA_WIDTH-1:0] o_link_data,
  output logic                  o_halted
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(1);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] pend_target;
  logic                  pend_return;
  logic [DATA_WIDTH-1:0] pend_addr;

  // Single FSM: next state, PC, parked jump and registered strobes together.
  // NOTE: every register here uses <= so all of them sample the pre-edge
  // values of each other; a blocking = would let later lines see updated state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= ST_RUN;
      o_pc         <= RESET_PC;
      o_flush      <= 1'b0;
      o_link_valid <= 1'b0;
      o_link_data  <= '0;
      o_halted     <= 1'b0;
      pend_target  <= '0;
      pend_return  <= 1'b0;
      pend_addr    <= '0;
    end else if (i_enable) begin
      // Strobes default low; only the edge that loads a target raises them.
      o_flush      <= 1'b0;
      o_link_valid <= 1'b0;
      case (state)
        ST_RUN: begin
          if (i_halt) begin
            // Halt wins over a concurrent jump, which is dropped.
            state    <= ST_HALTED;
            o_halted <= 1'b1;
          end else if (i_jump && !i_stall) begin
            o_pc    <= i_pcjump;
            o_flush <= 1'b1;
            state   <= ST_REDIRECT;
            if (i_return) begin
              o_link_valid <= 1'b1;
              o_link_data  <= i_return_address;
            end
          end else if (i_jump) begin
            // Stalled jump: park it until the hazard clears.
            pend_target <= i_pcjump;
            pend_return <= i_return;
            pend_addr   <= i_return_address;
            state       <= ST_PEND;
          end else if (!i_stall) begin
            o_pc <= o_pc + PC_STEP;
          end
        end
        ST_PEND: begin
          // New jumps are ignored; only the stall release matters here.
          if (!i_stall) begin
            o_pc    <= pend_target;
            o_flush <= 1'b1;
            state   <= ST_REDIRECT;
            if (pend_return) begin
              o_link_valid <= 1'b1;
              o_link_data  <= pend_addr;
            end
          end
        end
        ST_REDIRECT: begin
          // Decode holds the flushed instruction, so jump/halt are ignored.
          if (!i_stall) begin
            o_pc <= o_pc + PC_STEP;
          end
          state <= ST_RUN;
        end
        ST_HALTED: begin
          state    <= ST_HALTED;
          o_halted <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule : u_fetch_redirect

// File: doc/u_fetch_redirect.md
U_FETCH_REDIRECT -- requirements
Module: u_fetch_redirect

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the width of the PC, jump target and link data.
REQ-002 Parameter RESET_PC, default 0, is the PC value loaded on reset.
REQ-003 Port i_clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port i_reset, input, 1 bit, is an asynchronous, active-low reset.
REQ-005 Port i_enable, input, 1 bit, is the run/step enable from the debug unit; when 0, all state freezes.
REQ-006 Port i_stall, input, 1 bit, is the hazard-unit stall; when 1, the PC is held.
REQ-007 Port i_halt, input, 1 bit, signals that a HALT instruction has been decoded.
REQ-008 Port i_jump, input, 1 bit, is the jump request from decode.
REQ-009 Port i_pcjump, input, DATA_WIDTH bits, is the jump target (word address).
REQ-010 Port i_return, input, 1 bit, indicates the jump writes a link value.
REQ-011 Port i_return_address, input, DATA_WIDTH bits, is the link value.
REQ-012 Port o_pc, output, DATA_WIDTH bits, is the registered fetch PC.
REQ-013 Port o_flush, output, 1 bit, is a registered one-cycle bubble strobe for the IF/ID register.
REQ-014 Port o_link_valid, output, 1 bit, is a one-cycle strobe marking an accepted linking jump.
REQ-015 Port o_link_data, output, DATA_WIDTH bits, is the link value, valid while o_link_valid is 1.
REQ-016 Port o_halted, output, 1 bit, is 1 while the state machine is in HALTED.

Function
REQ-017 The block SHALL use the states RUN, PEND, REDIRECT and HALTED; nothing changes in any state while i_enable=0.
REQ-018 RUN, priority order:
- i_halt=1 -> HALTED, PC held, any concurrent jump dropped.
- i_jump=1 and i_stall=0 -> o_pc<=i_pcjump, go to REDIRECT.
- i_jump=1 and i_stall=1 -> latch target, i_return and i_return_address; go to PEND; PC held.
- Otherwise, if i_stall=0 -> o_pc<=o_pc+1.
REQ-019 PEND:
- While i_stall=1, hold the PC and the latched values; new i_jump is ignored.
- On i_stall=0 -> o_pc<=latched target, go to REDIRECT.
REQ-020 REDIRECT:
- o_flush=1 for exactly this cycle.
- o_pc<=o_pc+1 if i_stall=0.
- i_jump and i_halt are ignored (the decode slot holds a flushed instruction).
- Go to RUN.
REQ-021 HALTED:
- o_pc is frozen; all inputs except i_reset are ignored.
- o_halted=1; the state is left only by reset.
REQ-022 Link timing: on the edge where a jump target is loaded with return=1, o_link_valid=1 and o_link_data=return address for the following cycle only. A jump with return=0 produces no strobe.
REQ-023 PC arithmetic is modulo 2^DATA_WIDTH: all-ones+1 wraps to 0. The target is used unmodified.
REQ-024 Latency: the target appears on o_pc one edge after acceptance. o_flush and o_link_valid assert in that same next cycle.

Reset
REQ-025 While i_reset=0:
- o_pc=RESET_PC; o_flush=0, o_link_valid=0, o_link_data=0, o_halted=0.
- Latched pending values=0; state=RUN.
- All of this applies immediately, regardless of the clock.
REQ-026 Reset asserted in PEND or REDIRECT SHALL discard the pending jump with no flush or link strobe afterwards.

Structure
REQ-027 The state encoding (2-bit localparams), DATA_WIDTH and RESET_PC defaults belong in the shared MIPS package.
REQ-028 No sub-module: one FSM plus PC, pending and strobe registers in a single module.

Verification
REQ-029 Reset release, enable=1, no jump, 3 cycles -> o_pc 0,1,2,3; o_flush=0 throughout.
REQ-030 At pc=5: jump=1, target=0x40, return=1, ret_addr=6, stall=0 -> next cycle o_pc=0x40, o_flush=1, o_link_valid=1, o_link_data=6; following cycle o_pc=0x41, strobes=0.
REQ-031 Jump target 0x80 with stall=1 for 2 cycles -> o_pc held, state PEND; stall drops -> o_pc=0x80 and o_flush=1 next cycle.
REQ-032 halt=1 and jump=1 in the same cycle -> o_halted=1, o_pc unchanged, no flush; later jumps ignored until reset.
REQ-033 PC=0xFFFFFFFF, no stall -> o_pc=0. Also: enable=0 during REDIRECT holds o_flush=1 and the PC until enable returns.
REQ-034 i_reset=0 asynchronously mid-PEND -> o_pc=0 immediately; after release, no flush or link strobe.
